// File: rtl/alu_seq.sv
// alu_seq: registered 16-op ALU stage with 8-cycle shift-add multiply and Busy/Done handshake.
module alu_seq (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [3:0] FunSel,
    input  logic       Start,
    input  logic       WF,
    output logic [7:0] OutALU,
    output logic [3:0] Flags,
    output logic       Busy,
    output logic       Done
);
    typedef enum logic {IDLE, MUL} state_t;
    state_t      state_q;
    logic [7:0]  out_q, a_q, b_q;
    logic [3:0]  flags_q;
    logic        busy_q, done_q, wf_q;
    logic [15:0] acc_q, acc_d;
    logic [2:0]  cnt_q;
    logic [7:0]  res;
    logic [8:0]  s9;
    logic        cf, of;
    // Single-cycle datapath; flags index {Z,C,N,O} = [3:0], so C is bit 2 and O is bit 0.
    always_comb begin
        res = A;
        s9  = 9'h000;
        cf  = flags_q[2];
        of  = flags_q[0];
        case (FunSel)
            4'h0: res = A;
            4'h1: res = B;
            4'h2: res = ~A;
            4'h3: res = ~B;
            4'h4: begin
                s9  = {1'b0, A} + {1'b0, B};
                res = s9[7:0];
                cf  = s9[8];
                of  = (A[7] == B[7]) && (res[7] != A[7]);
            end
            4'h5: begin
                s9  = {1'b0, A} + {1'b0, B} + {8'h00, flags_q[2]};
                res = s9[7:0];
                cf  = s9[8];
                of  = (A[7] == B[7]) && (res[7] != A[7]);
            end
            4'h6: begin
                s9  = {1'b0, A} - {1'b0, B};
                res = s9[7:0];
                cf  = s9[8];
                of  = (A[7] != B[7]) && (res[7] != A[7]);
            end
            4'h7: res = A & B;
            4'h8: res = A | B;
            4'h9: res = A ^ B;
            4'hA: begin res = {A[6:0], 1'b0};       cf = A[7]; end
            4'hB: begin res = {1'b0, A[7:1]};       cf = A[0]; end
            4'hC: begin res = {A[7], A[7:1]};       cf = A[0]; of = 1'b0; end
            4'hD: begin res = {A[6:0], flags_q[2]}; cf = A[7]; end
            4'hE: begin res = {flags_q[2], A[7:1]}; cf = A[0]; end
            default: res = A;
        endcase
    end
    assign acc_d = acc_q + (b_q[cnt_q] ? ({8'h00, a_q} << cnt_q) : 16'h0000);
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            out_q   <= 8'h00;
            flags_q <= 4'h0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wf_q    <= 1'b0;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            acc_q   <= 16'h0000;
            cnt_q   <= 3'd0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (Start && FunSel == 4'hF) begin
                    a_q     <= A;
                    b_q     <= B;
                    wf_q    <= WF;
                    acc_q   <= 16'h0000;
                    cnt_q   <= 3'd0;
                    busy_q  <= 1'b1;
                    state_q <= MUL;
                end else if (Start) begin
                    out_q  <= res;
                    done_q <= 1'b1;
                    if (WF) flags_q <= {res == 8'h00, cf, res[7], of};
                end
            end else begin
                acc_q <= acc_d;
                cnt_q <= cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    out_q   <= acc_d[7:0];
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    if (wf_q) flags_q <= {acc_d[7:0] == 8'h00, |acc_d[15:8], acc_d[7], flags_q[0]};
                end
            end
        end
    end
    assign OutALU = out_q;
    assign Flags  = flags_q;
    assign Busy   = busy_q;
    assign Done   = done_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq.
module tb_alu_seq;
    logic       Clock, Reset, Start, WF, Busy, Done;
    logic [7:0] A, B, OutALU;
    logic [3:0] FunSel, Flags;
    int checks = 0;
    int failures = 0;

    alu_seq dut (
        .Clock(Clock), .Reset(Reset), .A(A), .B(B), .FunSel(FunSel), .Start(Start),
        .WF(WF), .OutALU(OutALU), .Flags(Flags), .Busy(Busy), .Done(Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic start_op(input logic [3:0] fs, input logic [7:0] a, input logic [7:0] b, input logic wf);
        @(negedge Clock);
        FunSel = fs; A = a; B = b; WF = wf; Start = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
    endtask

    task automatic next_edge();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) next_edge();
        checks++;
        if ({OutALU, Flags, Busy, Done} !== 14'h0) begin
            failures++;
            $display("FAIL reset out=%h flags=%b busy=%b done=%b exp 00/0000/0/0", OutALU, Flags, Busy, Done);
        end
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic test_add();
        start_op(4'h4, 8'h7F, 8'h01, 1'b1);
        checks++;
        if ({OutALU, Flags, Done} !== {8'h80, 4'b0011, 1'b1}) begin
            failures++;
            $display("FAIL add out=%h flags=%b done=%b exp 80/0011/1", OutALU, Flags, Done);
        end
        next_edge();
        checks++;
        if (Done !== 1'b0) begin
            failures++;
            $display("FAIL add_done_pulse done=%b exp 0", Done);
        end
        start_op(4'h4, 8'hFF, 8'h01, 1'b0);
        checks++;
        if ({OutALU, Flags, Done} !== {8'h00, 4'b0011, 1'b1}) begin
            failures++;
            $display("FAIL add_nowf out=%h flags=%b done=%b exp 00/0011/1", OutALU, Flags, Done);
        end
    endtask

    task automatic test_sub_adc();
        start_op(4'h6, 8'h05, 8'h07, 1'b1);
        checks++;
        if ({OutALU, Flags} !== {8'hFE, 4'b0110}) begin
            failures++;
            $display("FAIL sub out=%h flags=%b exp FE/0110", OutALU, Flags);
        end
        start_op(4'h5, 8'h01, 8'h01, 1'b1);
        checks++;
        if ({OutALU, Flags} !== {8'h03, 4'b0000}) begin
            failures++;
            $display("FAIL adc out=%h flags=%b exp 03/0000", OutALU, Flags);
        end
    endtask

    task automatic test_shift();
        start_op(4'hD, 8'h81, 8'h00, 1'b1);
        checks++;
        if ({OutALU, Flags} !== {8'h02, 4'b0100}) begin
            failures++;
            $display("FAIL rol out=%h flags=%b exp 02/0100", OutALU, Flags);
        end
        start_op(4'hE, 8'h02, 8'h00, 1'b1);
        checks++;
        if ({OutALU, Flags} !== {8'h81, 4'b0010}) begin
            failures++;
            $display("FAIL ror out=%h flags=%b exp 81/0010", OutALU, Flags);
        end
        start_op(4'hC, 8'h80, 8'h00, 1'b1);
        checks++;
        if ({OutALU, Flags} !== {8'hC0, 4'b0010}) begin
            failures++;
            $display("FAIL asr out=%h flags=%b exp C0/0010", OutALU, Flags);
        end
    endtask

    task automatic test_logic();
        start_op(4'h9, 8'hF0, 8'h3C, 1'b1);
        checks++;
        if ({OutALU, Flags} !== {8'hCC, 4'b0010}) begin
            failures++;
            $display("FAIL xor out=%h flags=%b exp CC/0010", OutALU, Flags);
        end
        start_op(4'h7, 8'hF0, 8'h0F, 1'b1);
        checks++;
        if ({OutALU, Flags} !== {8'h00, 4'b1000}) begin
            failures++;
            $display("FAIL and out=%h flags=%b exp 00/1000", OutALU, Flags);
        end
        start_op(4'hB, 8'h03, 8'h00, 1'b1);
        checks++;
        if ({OutALU, Flags} !== {8'h01, 4'b0100}) begin
            failures++;
            $display("FAIL lsr out=%h flags=%b exp 01/0100", OutALU, Flags);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge Clock);
        FunSel = 4'h8; A = 8'h0F; B = 8'hF0; WF = 1'b0; Start = 1'b1;
        next_edge();
        checks++;
        if ({OutALU, Done} !== {8'hFF, 1'b1}) begin
            failures++;
            $display("FAIL b2b_first out=%h done=%b exp FF/1", OutALU, Done);
        end
        FunSel = 4'h2;
        next_edge();
        Start = 1'b0;
        checks++;
        if ({OutALU, Done, Flags} !== {8'hF0, 1'b1, 4'b0100}) begin
            failures++;
            $display("FAIL b2b_second out=%h done=%b flags=%b exp F0/1/0100", OutALU, Done, Flags);
        end
    endtask

    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic meddle,
                           input logic [7:0] exp_out, input logic [3:0] exp_flags);
        int bad = 0;
        start_op(4'hF, a, b, 1'b1);
        for (int i = 0; i < 7; i++) begin
            if (Busy !== 1'b1 || Done !== 1'b0) bad++;
            if (meddle && i < 6) begin
                @(negedge Clock);
                A = ~A; B = 8'h55; FunSel = 4'h0; Start = 1'b1;
            end
            next_edge();
        end
        Start = 1'b0;
        if (Busy !== 1'b1 || Done !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mul_busy bad_cycles=%0d exp 0", bad);
        end
        next_edge();
        checks++;
        if ({OutALU, Flags, Busy, Done} !== {exp_out, exp_flags, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL mul_%h_%h out=%h flags=%b busy=%b done=%b exp %h/%b/0/1",
                     a, b, OutALU, Flags, Busy, Done, exp_out, exp_flags);
        end
        next_edge();
        checks++;
        if ({OutALU, Done} !== {exp_out, 1'b0}) begin
            failures++;
            $display("FAIL mul_after out=%h done=%b exp %h/0", OutALU, Done, exp_out);
        end
    endtask

    task automatic test_mul();
        run_mul(8'h13, 8'h0D, 1'b0, 8'hF7, 4'b0010);
        run_mul(8'h20, 8'h10, 1'b0, 8'h00, 4'b1100);
        run_mul(8'h13, 8'h0D, 1'b1, 8'hF7, 4'b0010);
    endtask

    task automatic test_reset_mid_mul();
        int dones = 0;
        start_op(4'hF, 8'h13, 8'h0D, 1'b1);
        repeat (3) next_edge();
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        checks++;
        if ({OutALU, Flags, Busy, Done} !== 14'h0) begin
            failures++;
            $display("FAIL reset_mid_mul out=%h flags=%b busy=%b done=%b exp 00/0000/0/0", OutALU, Flags, Busy, Done);
        end
        @(negedge Clock);
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            next_edge();
            if (Done !== 1'b0 || Busy !== 1'b0 || OutALU !== 8'h00) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL reset_mid_mul_quiet bad_cycles=%0d exp 0", dones);
        end
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; WF = 1'b0; A = 8'h00; B = 8'h00; FunSel = 4'h0;
        test_reset();
        test_add();
        test_sub_adc();
        test_shift();
        test_logic();
        test_back_to_back();
        test_mul();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
